// File: rtl/ec_point_check_if.sv
// Handshake and result bus between the point multiplier, the curve checker and its consumer.
interface ec_point_check_if #(parameter int DATA_WIDTH = 256);
  logic [DATA_WIDTH-1:0] Rx;
  logic [DATA_WIDTH-1:0] Ry;
  logic                  in_valid;
  logic                  in_ready;
  logic                  on_curve;
  logic                  range_err;
  logic                  out_valid;

  modport master (output Rx, Ry, in_valid, input in_ready, on_curve, range_err, out_valid);
  modport slave  (input Rx, Ry, in_valid, output in_ready, on_curve, range_err, out_valid);
endinterface

// File: rtl/ec_point_check.sv
// Curve-membership check y^2 == x^3 + A*x + B (mod P) using a bit-serial interleaved modmul.
// Optional macro ECC_PTCHK_A0_SKIP_EN: when A==0 the A*x multiply is skipped (latency 3*W+3).
module ec_point_check #(
  parameter int                    DATA_WIDTH = 256,
  parameter logic [DATA_WIDTH-1:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [DATA_WIDTH-1:0] A = '0,
  parameter logic [DATA_WIDTH-1:0] B = DATA_WIDTH'(7)
) (
  input  logic             clk,
  input  logic             rst,
  ec_point_check_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W+1:0] PX = {2'b00, P};
`ifdef ECC_PTCHK_A0_SKIP_EN
  localparam bit SKIP_A = (A == '0);
`else
  localparam bit SKIP_A = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD1, S_ADD2, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d, t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, s_q, s_d, acc_q, acc_d;
  logic           rerr_q, rerr_d, on_curve_q, on_curve_d, range_err_q, range_err_d;
  logic           out_valid_q, out_valid_d;

  logic [W-1:0]   mul_a, mul_b, acc_in, add_x, add_y;
  logic           mbit, mul_last, x_bad, y_bad;
  logic [W+1:0]   dbl, dbl_r, sum, sum_r, add_s, add_r;

  // One interleaved step: acc = 2*acc mod P, then acc += bit ? a : 0 mod P.
  always_comb begin
    unique case (op_q)
      2'd0:    begin mul_a = y_q;  mul_b = y_q; end
      2'd1:    begin mul_a = x_q;  mul_b = x_q; end
      2'd2:    begin mul_a = t1_q; mul_b = x_q; end
      default: begin mul_a = A;    mul_b = x_q; end
    endcase
    mbit     = mul_b[CW'(W-1) - cnt_q];
    mul_last = (cnt_q == CW'(W-1));
    acc_in   = (cnt_q == '0) ? '0 : acc_q;
    dbl      = {1'b0, acc_in, 1'b0};
    dbl_r    = (dbl >= PX) ? dbl - PX : dbl;
    sum      = dbl_r + (mbit ? {2'b00, mul_a} : '0);
    sum_r    = (sum >= PX) ? sum - PX : sum;
    add_x    = (state_q == S_ADD1) ? t1_q : s_q;
    add_y    = (state_q == S_ADD1) ? t2_q : B;
    add_s    = {2'b00, add_x} + {2'b00, add_y};
    add_r    = (add_s >= PX) ? add_s - PX : add_s;
    x_bad    = (bus.Rx >= P);
    y_bad    = (bus.Ry >= P);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) begin
        state_d = S_MUL;
        op_d    = '0;
        cnt_d   = '0;
      end
      S_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_last) begin
          cnt_d = '0;
          if (op_q == 2'd3 || (op_q == 2'd2 && SKIP_A)) state_d = S_ADD1;
          else                                          op_d    = op_q + 2'd1;
        end
      end
      S_ADD1:  state_d = S_ADD2;
      S_ADD2:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d = x_q;  y_d = y_q;  t0_d = t0_q;  t1_d = t1_q;  t2_d = t2_q;  s_d = s_q;  acc_d = acc_q;
    rerr_d      = rerr_q;
    on_curve_d  = on_curve_q;
    range_err_d = range_err_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) begin
        // Out-of-range coordinates are zeroed so the datapath invariant (operands < P) holds.
        rerr_d = x_bad | y_bad;
        x_d    = x_bad ? '0 : bus.Rx;
        y_d    = y_bad ? '0 : bus.Ry;
        t2_d   = '0;
      end
      S_MUL: begin
        acc_d = sum_r[W-1:0];
        if (mul_last) begin
          unique case (op_q)
            2'd0:    t0_d = sum_r[W-1:0];
            2'd3:    t2_d = sum_r[W-1:0];
            default: t1_d = sum_r[W-1:0];
          endcase
        end
      end
      S_ADD1, S_ADD2: s_d = add_r[W-1:0];
      S_DONE: begin
        on_curve_d  = (s_q == t0_q) & ~rerr_q;
        range_err_d = rerr_q;
        out_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;  y_q <= '0;  t0_q <= '0;  t1_q <= '0;  t2_q <= '0;  s_q <= '0;  acc_q <= '0;
      rerr_q      <= 1'b0;
      on_curve_q  <= 1'b0;
      range_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      x_q <= x_d;  y_q <= y_d;  t0_q <= t0_d;  t1_q <= t1_d;  t2_q <= t2_d;  s_q <= s_d;  acc_q <= acc_d;
      rerr_q      <= rerr_d;
      on_curve_q  <= on_curve_d;
      range_err_q <= range_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = out_valid_q;
    bus.on_curve  = on_curve_q;
    bus.range_err = range_err_q;
  end
endmodule

// File: tb/tb_ec_point_check.sv
// Self-checking bench for ec_point_check on secp256k1: fixed vectors plus randomized points vs. a wide-arithmetic model.
module tb_ec_point_check;
  localparam int W = 256;
  localparam logic [W-1:0] P  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [W-1:0] GX = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [W-1:0] GY = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [W-1:0] CA = '0;
  localparam logic [W-1:0] CB = 256'd7;
`ifdef ECC_PTCHK_A0_SKIP_EN
  localparam int LAT = 3*W + 3;
`else
  localparam int LAT = 4*W + 3;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ec_point_check_if #(.DATA_WIDTH(W)) bus ();
  ec_point_check dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference: evaluate the curve equation directly with full-width products.
  function automatic bit ref_on_curve(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [3*W-1:0] xx, yy, pp, aa, bb, lhs, rhs;
    xx = x; yy = y; pp = P; aa = CA; bb = CB;
    if (x >= P || y >= P) return 1'b0;
    lhs = (yy * yy) % pp;
    rhs = ((((xx * xx) % pp) * xx) + aa * xx + bb) % pp;
    return lhs == rhs;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_accept(input logic [W-1:0] x, input logic [W-1:0] y);
    bus.Rx = x; bus.Ry = y; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n, output bit got);
    n = 0; got = 1'b0;
    while (n < 2000 && !got) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.Rx = '0; bus.Ry = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.on_curve, bus.range_err} !== 4'b1000) begin
      fails++; $display("FAIL reset_state: got rdy/ov/oc/re=%b want 1000",
                        {bus.in_ready, bus.out_valid, bus.on_curve, bus.range_err});
    end
  endtask

  task automatic test_generator();
    int n; bit got;
    drive_accept(GX, GY);
    tests_run++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL gen_busy: in_ready=%b want 0", bus.in_ready); end
    wait_result(n, got);
    tests_run++;
    if (!got || n != LAT) begin fails++; $display("FAIL gen_latency: got=%0b edges=%0d want %0d", got, n, LAT); end
    tests_run++;
    if (bus.on_curve !== 1'b1 || bus.range_err !== 1'b0) begin
      fails++; $display("FAIL gen_result: oc=%b re=%b want 1 0", bus.on_curve, bus.range_err);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL gen_ready_at_done: in_ready=%b want 1", bus.in_ready); end
    @(posedge clk); #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.on_curve !== 1'b1) begin
      fails++; $display("FAIL gen_strobe_hold: ov=%b oc=%b want 0 1", bus.out_valid, bus.on_curve);
    end
  endtask

  task automatic test_not_on_curve();
    int n; bit got;
    drive_accept(GX, GY + 1'b1);
    wait_result(n, got);
    tests_run++;
    if (!got || n != LAT || bus.on_curve !== 1'b0 || bus.range_err !== 1'b0) begin
      fails++; $display("FAIL gy_plus1: got=%0b edges=%0d oc=%b re=%b want 1 %0d 0 0", got, n, bus.on_curve, bus.range_err, LAT);
    end
  endtask

  task automatic test_infinity();
    int n; bit got;
    drive_accept('0, '0);
    wait_result(n, got);
    tests_run++;
    if (!got || n != LAT || bus.on_curve !== 1'b0 || bus.range_err !== 1'b0) begin
      fails++; $display("FAIL infinity: got=%0b edges=%0d oc=%b re=%b want 1 %0d 0 0", got, n, bus.on_curve, bus.range_err, LAT);
    end
  endtask

  task automatic test_range();
    int n; bit got;
    drive_accept(P, GY);
    wait_result(n, got);
    tests_run++;
    if (!got || n != LAT || bus.on_curve !== 1'b0 || bus.range_err !== 1'b1) begin
      fails++; $display("FAIL range_x_eq_p: got=%0b edges=%0d oc=%b re=%b want 1 %0d 0 1", got, n, bus.on_curve, bus.range_err, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit got;
    drive_accept(GX, GY);
    n = 0;
    repeat (9) begin @(posedge clk); #1; n++; end
    bus.Rx = GX; bus.Ry = GY + 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1; n++;
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_busy: in_ready=%b want 0", bus.in_ready); end
    got = 1'b0;
    while (n < 2000 && !got) begin
      @(posedge clk); #1; n++;
      if (bus.out_valid) got = 1'b1;
    end
    tests_run++;
    if (!got || n != LAT || bus.on_curve !== 1'b1) begin
      fails++; $display("FAIL b2b_first: got=%0b edges=%0d oc=%b want 1 %0d 1", got, n, bus.on_curve, LAT);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: in_ready=%b want 1", bus.in_ready); end
    drive_accept(GX, GY + 1'b1);
    wait_result(n, got);
    tests_run++;
    if (!got || n != LAT || bus.on_curve !== 1'b0) begin
      fails++; $display("FAIL b2b_second: got=%0b edges=%0d oc=%b want 1 %0d 0", got, n, bus.on_curve, LAT);
    end
  endtask

  task automatic test_mid_reset();
    int n; bit got; int pulses;
    drive_accept(GX, GY);
    repeat (499) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.on_curve, bus.range_err} !== 4'b1000) begin
      fails++; $display("FAIL midrst_state: got rdy/ov/oc/re=%b want 1000",
                        {bus.in_ready, bus.out_valid, bus.on_curve, bus.range_err});
    end
    pulses = 0;
    repeat (2000) begin @(posedge clk); #1; if (bus.out_valid) pulses++; end
    tests_run++;
    if (pulses != 0) begin fails++; $display("FAIL midrst_no_result: out_valid pulses=%0d want 0", pulses); end
    drive_accept(GX, GY);
    wait_result(n, got);
    tests_run++;
    if (!got || n != LAT || bus.on_curve !== 1'b1) begin
      fails++; $display("FAIL midrst_reaccept: got=%0b edges=%0d oc=%b want 1 %0d 1", got, n, bus.on_curve, LAT);
    end
  endtask

  task automatic test_random();
    int n; bit got; bit exp_oc, exp_re;
    logic [W-1:0] x, y;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin x = rand_w(); y = rand_w(); end
        1: begin x = GX; y = P - GY; end
        2: begin x = P + W'($urandom_range(0, 1000)); y = rand_w() >> 1; end
        3: begin x = rand_w() >> 4; y = P - 1'b1; end
        4: begin x = rand_w(); y = GY; end
        default: begin x = GX; y = rand_w() | {W{1'b1}}; end
      endcase
      exp_re = (x >= P) || (y >= P);
      exp_oc = ref_on_curve(x, y);
      drive_accept(x, y);
      wait_result(n, got);
      tests_run++;
      if (!got || n != LAT || bus.on_curve !== exp_oc || bus.range_err !== exp_re) begin
        fails++; $display("FAIL random_%0d: got=%0b edges=%0d oc=%b re=%b want 1 %0d %b %b",
                          i, got, n, bus.on_curve, bus.range_err, LAT, exp_oc, exp_re);
      end
    end
  endtask

  initial begin
    test_reset();
    test_infinity();
    test_range();
    test_generator();
    test_mid_reset();
    test_not_on_curve();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/ec_point_check.md
Name: ec_point_check

Overview:
- Curve-membership checker placed directly downstream of the scalar point multiplier.
- Consumes the affine result (Rx, Ry) when the multiplier raises out_valid.
- Verifies y^2 = x^3 + A*x + B (mod P) with a bit-serial interleaved modular multiplier.
- Reports pass/fail plus a range-error flag before the point is released to signature/ECDH logic.

Parameters:
- DATA_WIDTH, 256, coordinate and field width W.
- P, secp256k1 prime FFFFFFFF...FFFFFFFE FFFFFC2F, field modulus; must be odd, greater than 2, and less than 2^W.
- A, 0, curve coefficient a; must be less than P.
- B, 7, curve coefficient b; must be less than P.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- Rx  input  DATA_WIDTH  affine x, sampled on accept.
- Ry  input  DATA_WIDTH  affine y, sampled on accept.
- in_valid  input  1  input qualifier; single-cycle pulse accepted.
- in_ready  output  1  high only in IDLE.
- on_curve  output  DATA_WIDTH-independent 1  result: point satisfies the curve equation.
- range_err  output  1  result: Rx >= P or Ry >= P.
- out_valid  output  1  one-cycle result strobe.

Behaviour:
- Reset (rst=1 at a rising edge):
  - outputs go to out_valid=0, on_curve=0, range_err=0, in_ready=1.
  - FSM goes to IDLE; all datapath registers are cleared.
  - Applies mid-operation too: any in-flight check is abandoned and no out_valid is produced for it.
- Accept: in IDLE with in_valid=1 at a rising edge.
  - Latch x=Rx, y=Ry.
  - Set range_err_r = (Rx>=P)|(Ry>=P).
  - An out-of-range coordinate is replaced internally by 0.
  - in_ready drops the next cycle.
  - in_valid outside IDLE is ignored; no queuing.
- FSM states: IDLE -> MUL (op index 0..3) -> ADD1 -> ADD2 -> DONE -> IDLE.
  - MUL op0: t0 = y*y.
  - MUL op1: t1 = x*x.
  - MUL op2: t1 = t1*x.
  - MUL op3: t2 = A*x.
  - ADD1: s = t1+t2 mod P.
  - ADD2: s = s+B mod P.
  - DONE: set on_curve = (s==t0) & ~range_err_r; assert out_valid for exactly one cycle; return to IDLE.
- Modular multiply a*b:
  - Exactly W cycles, multiplier bits scanned MSB first.
  - Per cycle: acc = 2*acc mod P, then acc = acc + (bit ? a : 0) mod P.
  - Intermediates are W+2 bits; each reduction is a single conditional subtract of P, valid because all operands are < P.
  - acc is cleared at the start of every multiply.
- Modular add: one cycle, sum W+1 bits, subtract P if sum >= P.
- Latency:
  - out_valid is high in the cycle following the (4*W+3)-th rising edge after the accept edge; 1027 edges for W=256.
  - Latency is fixed and data independent, range errors included.
- on_curve and range_err hold their values from the DONE edge until the next DONE edge or reset.
- in_ready returns to 1 in the same cycle out_valid is high, so a new accept is possible on the next edge (back-to-back).
- Point at infinity is encoded as (0,0) and reported as on_curve=0 whenever B != 0.

Optional Feature:
- Macro name: ECC_PTCHK_A0_SKIP_EN.
- Defined:
  - when parameter A==0, MUL op3 is skipped and t2 is forced to 0.
  - Latency becomes 3*W+3 (771 for W=256).
  - With A!=0, behaviour is identical to the undefined case.
- Undefined: all four multiplies always run; latency 4*W+3 regardless of A.

Test Plan:
1. Default parameters, Rx=79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, Ry=483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8 (generator G).
   -> out_valid 1027 edges after accept; on_curve=1, range_err=0.
2. Same Rx, Ry=...FB10D4B9 (Gy+1).
   -> on_curve=0, range_err=0, same latency.
3. Rx=0, Ry=0.
   -> on_curve=0, range_err=0.
4. Rx=P (FFFF...FC2F), Ry=Gy.
   -> on_curve=0, range_err=1, out_valid still at edge 1027.
5. Accept G, pulse in_valid with Gy+1 operands at edge 10; then accept Gy+1 on the edge after out_valid.
   -> in_ready=0 during busy; exactly one result (on_curve=1) for the first operation; second result on_curve=0 1027 edges after its accept.
6. Accept G, assert rst for one cycle at edge 500.
   -> no out_valid within 2000 edges; outputs 0; in_ready=1 the cycle after rst. Re-accept G: on_curve=1.
   With ECC_PTCHK_A0_SKIP_EN defined, repeat test 1 -> out_valid at edge 771.
